clk_freq_monitor: RTL and testbench
===================================

Name: clk_freq_monitor

Overview:
- Checks the 12 MHz USB clock from the USB rPLL against the 27 MHz board clock and produces the lock/valid indication that the PLL instance does not export.
- The block runs in the 27 MHz domain.
- Its input is a toggle signal that a divide-by-2 flop in the 12 MHz domain drives, outside this block. That flop gives a 6 MHz square wave, i.e. 12 M edges per second.
- The block counts edges over a fixed gate window, compares the count with an expected band, and asserts lock after several consecutive in-band windows. USB logic and the host reset sequencer consume the lock.

Parameters:
- WINDOW_CYCLES, 27000: gate window length in clk_i cycles (1 ms).
- EXP_COUNT, 12000: expected edge count per window.
- TOL, 60: allowed ± deviation from EXP_COUNT, inclusive.
- LOCK_WINDOWS, 4: consecutive in-band windows required to assert lock.
- CNT_W, 16: width of the edge counter and of meas_count_o.

Ports:
- clk_i, input, 1: 27 MHz system clock.
- rst_n_i, input, 1: asynchronous active-low reset.
- enable_i, input, 1: monitor enable, synchronous to clk_i.
- mon_toggle_i, input, 1: asynchronous toggle from the monitored clock domain.
- lock_o, output, 1: monitored clock is within band.
- meas_valid_o, output, 1: one-cycle pulse at the end of each window.
- meas_count_o, output, CNT_W: edge count of the last completed window.
- too_fast_o, output, 1: last window count > EXP_COUNT+TOL.
- too_slow_o, output, 1: last window count < EXP_COUNT−TOL.

Behaviour:
- Reset: every output is 0, all counters are 0, synchronizer flops are 0, and the FSM is UNLOCKED.
- Synchronizer and edge detect:
  - mon_toggle_i passes through a 2-FF synchronizer, then a third flop.
  - An edge is counted when flop 2 differs from flop 3.
  - Both edges are counted.
  - Edge-to-count latency is 3 cycles.
- Window counter:
  - Counts 0..WINDOW_CYCLES−1 while enable_i=1.
  - The last cycle of the window is the cycle with the counter at WINDOW_CYCLES−1.
  - On the last cycle, an edge detected in that same cycle is included in the closing window.
  - The edge counter then restarts at 0 on the next cycle. It does not lose or double-count the boundary edge.
- Edge counter saturates at 2^CNT_W−1 and never wraps.
- End of window (registered, visible the cycle after the last window cycle):
  - meas_valid_o pulses for 1 cycle.
  - meas_count_o is loaded with the count.
  - too_fast_o and too_slow_o are updated. They are mutually exclusive.
  - In-band means EXP_COUNT−TOL ≤ count ≤ EXP_COUNT+TOL. Compare in CNT_W+1 bits and clamp the lower bound at 0.
- FSM, updated only on window end:
  - UNLOCKED: in-band → CHECKING with good_cnt=1. Out-of-band → stay.
  - CHECKING: in-band → increment good_cnt. When good_cnt reaches LOCKING_WINDOWS → LOCKED. Out-of-band → UNLOCKED with good_cnt=0.
  - LOCKED: out-of-band → UNLOCKED with good_cnt=0 (a single bad window drops lock). In-band → stay.
  - LOCKING_WINDOWS=1 is legal: UNLOCKED goes directly to LOCKED.
- lock_o is 1 only in LOCKED and is registered. It rises in the same cycle as the meas_valid_o pulse of the qualifying window.
- Stuck monitored clock: count is 0, too_slow_o=1, and lock is lost at the next window end. Worst-case detection time is 2 windows.
- enable_i=0:
  - Takes effect in the next cycle and aborts the current window with no meas_valid_o pulse.
  - Clears the window counter, edge counter and good_cnt.
  - FSM goes to UNLOCKED and lock_o=0.
  - meas_count_o, too_fast_o and too_slow_o hold.
  - Re-enable starts a fresh window at count 0.
- Reset asserted mid-window clears everything immediately and asynchronously. Recovery needs LOCK_WINDOWS full windows.

Decomposition:
- Shared package usb_clk_pkg holds:
  - the FSM state enum (UNLOCKED, CHECKING, LOCKED);
  - constants SYS_CLK_HZ=27_000_000 and USB_CLK_HZ=12_000_000;
  - derived default EXP_COUNT.
- One sub-module: sync_edge_det, a 2-FF synchronizer plus edge-detect flop with a 1-bit edge pulse output. It will be reused for other async inputs.

Test Plan:
- 6 MHz toggle (12 M edges/s), enable held high: each window gives meas_count_o=12000 ±1. lock_o rises on the 4th meas_valid_o pulse, at 4×27000 cycles plus a few cycles of latency.
- Locked, then toggle frequency changed to 6.1 MHz (count ≈12200): too_fast_o=1 and lock_o=0 at that window's end. Restore 6 MHz: relock after 4 windows.
- Toggle stopped while locked: next window count=0, too_slow_o=1, lock_o=0. No meas_count_o wrap or X.
- Edge forced on the last window cycle, over 100 windows: the sum of meas_count_o equals the total edges driven, showing no loss or double-count at the boundary.
- enable_i dropped mid-window at cycle 13000: no meas_valid_o pulse, lock_o=0 next cycle, meas_count_o unchanged. Re-enable: the first pulse comes exactly 27000 cycles later.
- rst_n_i pulsed asynchronously mid-window while locked: all outputs are 0 immediately. lock_o returns after 4 windows. TOL=0 build: count 12001 is flagged too_fast_o.

Source files
------------

// File: rtl/usb_clk_pkg.sv
// Shared types and clock constants for the USB clock monitor.
// Defaults assume a 1 ms gate window in the board clock domain.
package usb_clk_pkg;

  localparam int unsigned SYS_CLK_HZ = 27_000_000;
  localparam int unsigned USB_CLK_HZ = 12_000_000;
  localparam int unsigned GATE_HZ    = 1000;

  localparam int unsigned DEF_WINDOW_CYCLES = SYS_CLK_HZ / GATE_HZ;
  // div-by-2 toggle yields one edge per monitored clock period
  localparam int unsigned DEF_EXP_COUNT     = USB_CLK_HZ / GATE_HZ;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECKING = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer plus a history flop; pulses on either edge
// of an asynchronous level input.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Gated edge counter that qualifies the USB PLL clock against
// the board clock and derives a lock indication.
module clk_freq_monitor
  import usb_clk_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned EXP_COUNT     = DEF_EXP_COUNT,
  parameter int unsigned TOL           = 60,
  parameter int unsigned LOCK_WINDOWS  = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             mon_toggle_i,
  output logic             lock_o,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] meas_count_o,
  output logic             too_fast_o,
  output logic             too_slow_o
);

  localparam int unsigned WIN_W =
    (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned LO_I =
    (EXP_COUNT > TOL) ? EXP_COUNT - TOL : 0;
  localparam int unsigned HI_I = EXP_COUNT + TOL;

  localparam logic [CNT_W:0] BAND_LO = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0] BAND_HI = (CNT_W+1)'(HI_I);
  localparam logic [WIN_W-1:0] WIN_LAST =
    WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_WINDOWS);

  logic tog_edge;

  sync_edge_det u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (mon_toggle_i),
    .edge_o  (tog_edge)
  );

  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  lock_state_e       state_q, state_d;
  logic              lock_q, lock_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fast_q, fast_d;
  logic              slow_q, slow_d;

  logic             last_win;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] close_cnt;
  logic             above;
  logic             below;
  logic             in_band;

  assign last_win = enable_i && (win_q == WIN_LAST);

  // edge of the current cycle is folded in, so the closing
  // window owns any edge seen on its last cycle
  assign sum       = {1'b0, cnt_q} + (CNT_W+1)'(tog_edge);
  assign close_cnt = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  assign above     = {1'b0, close_cnt} > BAND_HI;
  assign below     = {1'b0, close_cnt} < BAND_LO;
  assign in_band   = !above && !below;
  assign good_inc  = good_q + GOOD_W'(1);

  always_comb begin
    win_d   = win_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    count_d = count_q;
    fast_d  = fast_q;
    slow_d  = slow_q;
    if (!enable_i) begin
      win_d = '0;
      cnt_d = '0;
    end else if (last_win) begin
      win_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b1;
      count_d = close_cnt;
      fast_d  = above;
      slow_d  = below;
    end else begin
      win_d = win_q + WIN_W'(1);
      cnt_d = close_cnt;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (!enable_i) begin
      state_d = UNLOCKED;
      good_d  = '0;
    end else if (last_win) begin
      if (!in_band) begin
        state_d = UNLOCKED;
        good_d  = '0;
      end else begin
        unique case (state_q)
          UNLOCKED: begin
            good_d  = GOOD_W'(1);
            state_d = (GOOD_TGT <= GOOD_W'(1)) ? LOCKED : CHECKING;
          end
          CHECKING: begin
            good_d = good_inc;
            if (good_inc >= GOOD_TGT) state_d = LOCKED;
          end
          LOCKED: begin
            state_d = LOCKED;
          end
          default: begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
        endcase
      end
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_q   <= '0;
      cnt_q   <= '0;
      good_q  <= '0;
      state_q <= UNLOCKED;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      fast_q  <= 1'b0;
      slow_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      state_q <= state_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      count_q <= count_d;
      fast_q  <= fast_d;
      slow_q  <= slow_d;
    end
  end

  assign lock_o       = lock_q;
  assign meas_valid_o = valid_q;
  assign meas_count_o = count_q;
  assign too_fast_o   = fast_q;
  assign too_slow_o   = slow_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor with a scaled-down 100-cycle window
// and a phase-accumulator toggle source.
module tb_clk_freq_monitor;

  localparam int W     = 100;
  localparam int EXP   = 40;
  localparam int TOLV  = 2;
  localparam int LOCKN = 4;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  logic enable_i = 1'b0;
  logic mon_toggle_i = 1'b0;

  logic          lock_o, meas_valid_o, too_fast_o, too_slow_o;
  logic [CW-1:0] meas_count_o;
  logic          z_lock, z_valid, z_fast, z_slow;
  logic [CW-1:0] z_count;

  int n_checks = 0;
  int n_errors = 0;
  int rate = 0;

  always #5 clk = ~clk;

  clk_freq_monitor #(
    .WINDOW_CYCLES(W), .EXP_COUNT(EXP), .TOL(TOLV),
    .LOCK_WINDOWS(LOCKN), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i),
    .mon_toggle_i(mon_toggle_i), .lock_o(lock_o),
    .meas_valid_o(meas_valid_o), .meas_count_o(meas_count_o),
    .too_fast_o(too_fast_o), .too_slow_o(too_slow_o)
  );

  clk_freq_monitor #(
    .WINDOW_CYCLES(W), .EXP_COUNT(EXP), .TOL(0),
    .LOCK_WINDOWS(LOCKN), .CNT_W(CW)
  ) dut0 (
    .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i),
    .mon_toggle_i(mon_toggle_i), .lock_o(z_lock),
    .meas_valid_o(z_valid), .meas_count_o(z_count),
    .too_fast_o(z_fast), .too_slow_o(z_slow)
  );

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // toggle source: exactly `rate` edges per 100 clock cycles
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(posedge clk);
      #1;
      acc += rate;
      if (acc >= 100) begin
        acc -= 100;
        mon_toggle_i = ~mon_toggle_i;
      end
    end
  end

  // Model: toggle edges reach the count 3 samples late; a window is
  // W enabled cycles; lock = at least LOCKN consecutive good windows.
  logic ms [4];
  int   m_win, m_acc, m_run, m_tot, m_count;
  logic m_lock, m_valid, m_fast, m_slow, m_e;
  bit   armed = 1'b0;

  always @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) ms[i] = 1'b0;
      m_win = 0; m_acc = 0; m_run = 0; m_count = 0;
      m_lock = 0; m_valid = 0; m_fast = 0; m_slow = 0;
      armed = 1'b1;
    end else begin
      ms[3] = ms[2]; ms[2] = ms[1]; ms[1] = ms[0];
      ms[0] = mon_toggle_i;
      m_e = ms[2] ^ ms[3];
      m_valid = 1'b0;
      if (!enable_i) begin
        m_win = 0; m_acc = 0; m_run = 0; m_lock = 0;
      end else begin
        m_tot = m_acc + int'(m_e);
        if (m_tot > (1 << CW) - 1) m_tot = (1 << CW) - 1;
        if (m_win == W - 1) begin
          m_valid = 1'b1;
          m_count = m_tot;
          m_fast  = (m_tot > EXP + TOLV);
          m_slow  = (m_tot < EXP - TOLV);
          if (!m_fast && !m_slow)
            m_run = (m_run < LOCKN) ? m_run + 1 : LOCKN;
          else
            m_run = 0;
          m_lock = (m_run >= LOCKN);
          m_acc = 0;
          m_win = 0;
        end else begin
          m_acc = m_tot;
          m_win++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("lock", lock_o, m_lock);
      check("valid", meas_valid_o, m_valid);
      check("count", meas_count_o, m_count);
      check("fast", too_fast_o, m_fast);
      check("slow", too_slow_o, m_slow);
    end
  end

  task automatic wait_pulse();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (meas_valid_o !== 1'b1 && t < 400);
    check("pulse_wait", meas_valid_o, 1);
  endtask

  task automatic relock_seq(string tag);
    for (int k = 1; k <= 4; k++) begin
      wait_pulse();
      if (k < 4) check({tag, "_early"}, lock_o, 0);
    end
    check({tag, "_lock"}, lock_o, 1);
    check({tag, "_count"}, meas_count_o, EXP);
  endtask

  int rates [6]  = '{42, 43, 41, 38, 37, 40};
  bit e_fast [6] = '{0, 1, 0, 0, 0, 0};
  bit e_slow [6] = '{0, 0, 0, 0, 1, 0};
  bit z_efast [6] = '{1, 1, 1, 0, 0, 0};
  bit z_eslow [6] = '{0, 0, 0, 1, 1, 0};

  initial begin
    int sum;
    int saved;
    int cyc;

    repeat (3) @(negedge clk);
    check("rst_lock", lock_o, 0);
    check("rst_valid", meas_valid_o, 0);
    check("rst_count", meas_count_o, 0);
    check("rst_fast", too_fast_o, 0);
    check("rst_slow", too_slow_o, 0);

    enable_i = 1'b1;
    rate = 40;
    @(negedge clk);
    rst_n_i = 1'b1;
    relock_seq("init");

    for (int i = 0; i < 6; i++) begin
      rate = rates[i];
      wait_pulse();
      wait_pulse();
      check("band_count", meas_count_o, rates[i]);
      check("band_fast", too_fast_o, e_fast[i]);
      check("band_slow", too_slow_o, e_slow[i]);
      check("tol0_fast", z_fast, z_efast[i]);
      check("tol0_slow", z_slow, z_eslow[i]);
      if (i == 1) check("fast_unlock", lock_o, 0);
    end

    rate = 0;
    wait_pulse();
    wait_pulse();
    check("stuck_count", meas_count_o, 0);
    check("stuck_slow", too_slow_o, 1);
    check("stuck_lock", lock_o, 0);

    rate = 100;
    wait_pulse();
    wait_pulse();
    sum = 0;
    for (int k = 0; k < 9; k++) begin
      wait_pulse();
      sum += int'(meas_count_o);
    end
    check("edge_sum", sum, 900);
    check("sum_fast", too_fast_o, 1);

    rate = 40;
    repeat (5) wait_pulse();
    check("pre_dis_lock", lock_o, 1);
    repeat (50) @(negedge clk);
    saved = int'(meas_count_o);
    enable_i = 1'b0;
    @(negedge clk);
    check("dis_lock", lock_o, 0);
    check("dis_count", meas_count_o, saved);
    check("dis_valid", meas_valid_o, 0);
    repeat (30) @(negedge clk);
    enable_i = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (meas_valid_o !== 1'b1 && cyc < 1000);
    check("reen_latency", cyc, W);
    for (int k = 2; k <= 4; k++) begin
      wait_pulse();
      if (k < 4) check("reen_early", lock_o, 0);
    end
    check("reen_lock", lock_o, 1);

    @(posedge clk);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("arst_lock", lock_o, 0);
    check("arst_valid", meas_valid_o, 0);
    check("arst_count", meas_count_o, 0);
    check("arst_fast", too_fast_o, 0);
    check("arst_slow", too_slow_o, 0);
    repeat (3) @(negedge clk);
    rst_n_i = 1'b1;
    relock_seq("arst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
